performance_event_counters: RTL and testbench
=============================================

PERFORMANCE_EVENT_COUNTERS -- requirements
Module: performance_event_counters

Interface
REQ-001 Parameter INPUT_EVENT_BITMAP_WIDTH, default 115, SHALL set the number of event inputs and counters (legal range 1 and up).
REQ-002 Parameter COUNTER_WIDTH, default 64, SHALL set the width of each counter in bits (legal range 1 and up).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-high reset: 1 = reset, 0 = run (port keeps the codebase name).
REQ-005 performance_events  input  INPUT_EVENT_BITMAP_WIDTH  SHALL be the event bitmap; bit i = 1 means event i occurred this cycle.
REQ-006 counters  output  unpacked array [INPUT_EVENT_BITMAP_WIDTH-1:0] of COUNTER_WIDTH-bit words  SHALL be the registered count for each event; counters[i] pairs with performance_events[i].

Function
REQ-007 The block SHALL hold one independent COUNTER_WIDTH-bit register per event bit, each driving counters[i] directly with no combinational path from any input.
REQ-008 At each rising clk with rst_n = 0, counters[i] SHALL increment by exactly 1 if performance_events[i] = 1, and hold otherwise.
REQ-009 Increment latency SHALL be one cycle: an event sampled at edge N is visible on counters[i] after edge N.
REQ-010 Multiple bits set in the same cycle SHALL each increment their own counter by 1 in that cycle, with no interaction between counters.
REQ-011 Each counter SHALL wrap modulo 2^COUNTER_WIDTH: an event at value 2^COUNTER_WIDTH-1 SHALL produce 0, with no saturation or overflow flag.
REQ-012 An event bit held high for K consecutive cycles SHALL add K (mod 2^COUNTER_WIDTH); events are level-sampled each cycle, not edge-detected.
REQ-013 performance_events SHALL be treated as synchronous to clk; the block SHALL NOT add synchronizers.

Reset
REQ-014 At each rising clk with rst_n = 1, all counters SHALL load 0, regardless of performance_events.
REQ-015 Reset SHALL take priority over increment in the same cycle; an event present during a reset cycle SHALL NOT be counted.
REQ-016 Counting SHALL resume on the first rising edge with rst_n = 0 after reset: an event sampled at that edge SHALL produce count 1.
REQ-017 Reset asserted while counting is in progress SHALL clear all counters within one edge; there are no partial or per-counter resets.
REQ-018 Counter values before the first reset edge are undefined; verification SHALL apply reset before checking values.

Verification
REQ-019 Reset, then events = 'b001 for 5 cycles -> counters[0] = 5, counters[1] = 0, counters[2] = 0.
REQ-020 Reset, then the sequence 'b001, 'b101, 'b001, 'b011, 'b101, 'b001 -> counters[0] = 6, counters[1] = 1, counters[2] = 2, all other counters = 0.
REQ-021 With counters[0] = 7, assert rst_n = 1 for one cycle while events = 'b001, then 3 cycles of 'b001 with rst_n = 0 -> counters[0] = 0 after the reset edge, then 1, 2, 3.
REQ-022 COUNTER_WIDTH = 7, events[0] held high for 130 cycles after reset -> counters[0] reaches 127 at cycle 127, 0 at cycle 128, and 2 at cycle 130.
REQ-023 events = 0 for 20 cycles after reset -> all counters remain 0.
REQ-024 All 115 event bits high for 3 cycles after reset -> every counters[i] = 3, including counters[114].

Source files
------------

// File: rtl/performance_event_counters.sv
// Per-event free-running counters: one independent counter register per event-bitmap bit.
// Each counter is level-sampled, wraps modulo 2^COUNTER_WIDTH and clears on a synchronous reset.
module performance_event_counters #(
  parameter int INPUT_EVENT_BITMAP_WIDTH = 115,
  parameter int COUNTER_WIDTH            = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INPUT_EVENT_BITMAP_WIDTH-1:0] performance_events,
  output logic [COUNTER_WIDTH-1:0]            counters [INPUT_EVENT_BITMAP_WIDTH-1:0]
);

  // rst_n keeps its historical name but is active-high: 1 clears every counter.
  generate
    for (genvar gi = 0; gi < INPUT_EVENT_BITMAP_WIDTH; gi++) begin : g_counter
      logic [COUNTER_WIDTH-1:0] count_reg;
      logic [COUNTER_WIDTH-1:0] count_next;

      // Natural overflow of the adder provides the modulo-2^N wrap.
      always_comb begin
        count_next = count_reg;
        if (performance_events[gi]) begin
          count_next = count_reg + COUNTER_WIDTH'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign counters[gi] = count_reg;
    end
  endgenerate

endmodule

// File: tb/tb_performance_event_counters.sv
// Self-checking bench for performance_event_counters: directed scenarios plus randomized
// events and resets compared against a per-event count model.
module tb_performance_event_counters;
  localparam int N  = 115;
  localparam int W  = 64;
  localparam int N2 = 3;
  localparam int W2 = 7;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          ev;
  logic [W-1:0]          cnt [N-1:0];
  logic                  rst2;
  logic [N2-1:0]         ev2;
  logic [W2-1:0]         cnt2 [N2-1:0];

  logic [W-1:0]          model  [N];
  int                    model2 [N2];
  int                    total;
  int                    bad;

  performance_event_counters #(
    .INPUT_EVENT_BITMAP_WIDTH(N),
    .COUNTER_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst),
    .performance_events(ev),
    .counters(cnt)
  );

  performance_event_counters #(
    .INPUT_EVENT_BITMAP_WIDTH(N2),
    .COUNTER_WIDTH(W2)
  ) dut_small (
    .clk(clk),
    .rst_n(rst2),
    .performance_events(ev2),
    .counters(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; the model applies the counting rules to the inputs present at this edge.
  task automatic tick();
    for (int i = 0; i < N; i++) begin
      if (rst) model[i] = '0;
      else if (ev[i]) model[i] = model[i] + 64'd1;
    end
    for (int i = 0; i < N2; i++) begin
      if (rst2) model2[i] = 0;
      else if (ev2[i]) model2[i] = (model2[i] + 1) % 128;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev = '1; rst2 = 1'b1; ev2 = '1;
    tick();
    rst = 1'b0; ev = '0; rst2 = 1'b0; ev2 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev = '1; rst2 = 1'b1; ev2 = '1;
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] !== '0) begin
        bad++;
        $display("FAIL reset cnt[%0d]: got %0d expected 0", i, cnt[i]);
      end
    end
    for (int i = 0; i < N2; i++) begin
      total++;
      if (cnt2[i] !== '0) begin
        bad++;
        $display("FAIL reset cnt2[%0d]: got %0d expected 0", i, cnt2[i]);
      end
    end
    rst = 1'b0; ev = '0; rst2 = 1'b0; ev2 = '0;
  endtask

  task automatic test_single_bit();
    logic [W-1:0] exp_v [3];
    do_reset();
    ev = N'(3'b001);
    for (int c = 0; c < 5; c++) tick();
    ev = '0;
    exp_v[0] = 64'd5; exp_v[1] = 64'd0; exp_v[2] = 64'd0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cnt[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL single_bit cnt[%0d]: got %0d expected %0d", i, cnt[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_sequence();
    logic [2:0] pat [6];
    pat[0] = 3'b001; pat[1] = 3'b101; pat[2] = 3'b001;
    pat[3] = 3'b011; pat[4] = 3'b101; pat[5] = 3'b001;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      ev = N'(pat[c]);
      tick();
    end
    ev = '0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] e;
      e = (i == 0) ? 64'd6 : (i == 1) ? 64'd1 : (i == 2) ? 64'd2 : 64'd0;
      total++;
      if (cnt[i] !== e) begin
        bad++;
        $display("FAIL sequence cnt[%0d]: got %0d expected %0d", i, cnt[i], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ev = N'(3'b001);
    for (int c = 0; c < 7; c++) tick();
    total++;
    if (cnt[0] !== 64'd7) begin
      bad++;
      $display("FAIL reset_mid pre cnt[0]: got %0d expected 7", cnt[0]);
    end
    rst = 1'b1;
    tick();
    total++;
    if (cnt[0] !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid clear cnt[0]: got %0d expected 0", cnt[0]);
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (cnt[0] !== 64'(c)) begin
        bad++;
        $display("FAIL reset_mid resume cnt[0]: got %0d expected %0d", cnt[0], c);
      end
    end
    ev = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    ev2 = 3'b001;
    for (int c = 1; c <= 130; c++) begin
      tick();
      total++;
      if (cnt2[0] !== W2'(c % 128)) begin
        bad++;
        $display("FAIL wrap cnt2[0] cycle %0d: got %0d expected %0d", c, cnt2[0], c % 128);
      end
      if (c == 127 || c == 128 || c == 130) begin
        total++;
        if (cnt2[0] !== W2'(model2[0])) begin
          bad++;
          $display("FAIL wrap_model cnt2[0] cycle %0d: got %0d expected %0d", c, cnt2[0], model2[0]);
        end
      end
    end
    ev2 = '0;
    for (int i = 1; i < N2; i++) begin
      total++;
      if (cnt2[i] !== '0) begin
        bad++;
        $display("FAIL wrap_other cnt2[%0d]: got %0d expected 0", i, cnt2[i]);
      end
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (cnt[i] !== '0) begin
          bad++;
          $display("FAIL idle cnt[%0d] cycle %0d: got %0d expected 0", i, c, cnt[i]);
        end
      end
    end
  endtask

  task automatic test_all_high();
    do_reset();
    ev = '1;
    for (int c = 0; c < 3; c++) tick();
    ev = '0;
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] !== 64'd3) begin
        bad++;
        $display("FAIL all_high cnt[%0d]: got %0d expected 3", i, cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    int density;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      density = (c < 100) ? 2 : (c < 200) ? 4 : 16;
      for (int i = 0; i < N; i++) ev[i] = (($urandom % 16) < density);
      rst = (($urandom % 50) == 0);
      ev2 = 3'($urandom);
      rst2 = (($urandom % 60) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        total++;
        if (cnt[i] !== model[i]) begin
          bad++;
          $display("FAIL random cnt[%0d] cycle %0d: got %0d expected %0d", i, c, cnt[i], model[i]);
        end
      end
      for (int i = 0; i < N2; i++) begin
        total++;
        if (cnt2[i] !== W2'(model2[i])) begin
          bad++;
          $display("FAIL random cnt2[%0d] cycle %0d: got %0d expected %0d", i, c, cnt2[i], model2[i]);
        end
      end
    end
    rst = 1'b0; ev = '0; rst2 = 1'b0; ev2 = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; ev = '0; rst2 = 1'b1; ev2 = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int i = 0; i < N2; i++) model2[i] = 0;
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_sequence();
    test_reset_mid();
    test_wrap();
    test_idle();
    test_all_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
